bomb_placer: RTL and testbench
==============================

# bomb_placer

Upstream board generator for the minesweeper game logic. On `start` it places exactly `bombas` distinct bombs on the 8x8 board. Bomb positions come from a free-running 16-bit LFSR, and one player-selected cell is excluded as a safe cell. The block holds the resulting 64-bit bomb map and exposes a combinational cell read port (bomb flag plus adjacent-bomb count) that the game FSM queries at the cursor position.

## Interface
Parameters:
- `LFSR_SEED`, default `16'hACE1`: LFSR reset value; must be nonzero.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: single-cycle request to generate a new board.
- `bombas` in, 4: number of bombs to place, 0..15; sampled at the accepted `start`.
- `safe_x` in, 3: column of the cell that must stay bomb-free; sampled at the accepted `start`.
- `safe_y` in, 3: row of the cell that must stay bomb-free; sampled at the accepted `start`.
- `busy` out, 1: high while in CLEAR or PLACE.
- `done` out, 1: high while in DONE (board valid).
- `bomb_map` out, 64: bit `y*8+x` is 1 when cell (x,y) holds a bomb.
- `bomb_count` out, 4: bombs placed so far.
- `rd_x` in, 3: read-port column.
- `rd_y` in, 3: read-port row.
- `rd_bomb` out, 1: `bomb_map[rd_y*8+rd_x]`.
- `rd_adj` out, 4: bomb count in the 8-neighbourhood of (rd_x, rd_y), 0..8.

## Operation
- LFSR: 16-bit Galois with mask `16'hB400`. Each cycle, shift right and XOR the mask when the shifted-out bit is 1. It advances every cycle in every state; only `rst` stops it. The candidate cell is `lfsr[5:0]`, interpreted as index `y*8+x`.
- States: IDLE, CLEAR, PLACE, DONE.
- IDLE or DONE, `start`=1:
  - latch `target = bombas` and `safe_idx = {safe_y, safe_x}`;
  - go to CLEAR.
- CLEAR, one cycle:
  - `bomb_map` <= 0, `bomb_count` <= 0;
  - next state is DONE if `target`==0, else PLACE.
- PLACE, each cycle:
  - if the candidate is already a bomb or equals `safe_idx`, reject it; no change.
  - otherwise set the candidate's map bit and increment `bomb_count`.
  - when the incremented count equals `target`, go to DONE in the same edge.
- DONE: hold `bomb_map` and `bomb_count` until the next `start` or `rst`.
- `start` while busy (CLEAR or PLACE) is ignored; no re-latching.
- Termination: the LFSR period is 65535 and every 6-bit value recurs, so at most 15 of the 63 eligible cells are ever needed and placement always finishes.
- Read port is purely combinational and valid in any state; it reflects the current `bomb_map`.
  - Neighbours outside 0..7 on either axis count as 0. There is no wrap-around: x=0 has no x-1 neighbour, x=7 has no x+1 neighbour, and the same holds for y.
  - The centre cell is never counted in `rd_adj`.
  - `rd_adj` is computed as a 4-bit sum, so a maximum of 8 cannot overflow.

## Timing
- Reset values: state IDLE, `lfsr`=`LFSR_SEED`, `bomb_map`=0, `bomb_count`=0, `busy`=0, `done`=0, `target`=0, `safe_idx`=0.
- `start` accepted at edge T: CLEAR is active in cycle T+1, and `busy`=1 from T+1.
- `bombas`=0: DONE at T+2, so `done`=1 and `busy`=0 from T+2.
- `bombas`=N>0: the first placement is visible at the earliest at T+3. `done` rises on the cycle after the edge that writes the Nth bomb, so the minimum latency is T+2+N.
- `done` and `busy` are never both 1. `done` drops at the cycle after a new `start` is accepted.
- `rst` mid-PLACE: takes effect immediately. Map and count are cleared, and the next `start` behaves exactly as after power-up reset.
- Determinism: an identical cycle offset from reset to `start`, with identical inputs, produces an identical `bomb_map`.

## Test plan
- Reset: assert `rst` mid-operation, then release. Required: `busy`=0, `done`=0, `bomb_map`=0, `bomb_count`=0, `rd_adj`=0 for every cell.
- `bombas`=0, `start` at T. Required: `busy`=1 at T+1, `done`=1 at T+2, `bomb_map`=0.
- `bombas`=15, safe=(3,4). Required: `done` within 2000 cycles, popcount(`bomb_map`)=15, `bomb_count`=15, bit 35=0.
- After a completed board, sweep all 64 (`rd_x`,`rd_y`). Required: `rd_bomb` and `rd_adj` match a bench model computed from `bomb_map`, including the corners (0,0) and (7,7) and the edges x=0 and y=7.
- `start` pulsed again mid-PLACE with different `bombas`. Required: it is ignored; the final count equals the first `bombas`. A second `start` from DONE with `bombas`=5 gives a fresh board with popcount 5.
- Two runs with `start` at reset+20 cycles and identical inputs. Required: identical `bomb_map`. A run with `start` at reset+21 produces a different map.

Source files
------------

// File: rtl/bomb_placer.sv
// bomb_placer: places a requested number of distinct bombs on an 8x8 board from a free-running LFSR
module bomb_placer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  bombas,
    input  logic [2:0]  safe_x,
    input  logic [2:0]  safe_y,
    output logic        busy,
    output logic        done,
    output logic [63:0] bomb_map,
    output logic [3:0]  bomb_count,
    input  logic [2:0]  rd_x,
    input  logic [2:0]  rd_y,
    output logic        rd_bomb,
    output logic [3:0]  rd_adj
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] PLACE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [3:0]  target;
    logic [5:0]  safe_idx;
    logic [5:0]  cand;
    logic [4:0]  xs, ys;

    assign cand    = lfsr[5:0];
    assign busy    = (state == CLEAR) || (state == PLACE);
    assign done    = state == DONE;
    assign rd_bomb = bomb_map[{rd_y, rd_x}];

    // Galois LFSR runs every cycle regardless of state so start timing picks the board
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // board generation FSM: latch request, clear the map, then accept non-duplicate non-safe candidates
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            bomb_map   <= '0;
            bomb_count <= '0;
            target     <= '0;
            safe_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    target   <= bombas;
                    safe_idx <= {safe_y, safe_x};
                    state    <= CLEAR;
                end
                CLEAR: begin
                    bomb_map   <= '0;
                    bomb_count <= '0;
                    state      <= (target == 4'd0) ? DONE : PLACE;
                end
                PLACE: if (!bomb_map[cand] && cand != safe_idx) begin
                    bomb_map[cand] <= 1'b1;
                    bomb_count     <= bomb_count + 4'd1;
                    if (bomb_count + 4'd1 == target) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end

    // neighbour sum; offsets leaving 0..7 show up as nonzero bits [4:3] and are skipped
    always_comb begin
        rd_adj = '0;
        xs     = '0;
        ys     = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                xs = {2'b00, rd_x} + 5'(dx) - 5'd1;
                ys = {2'b00, rd_y} + 5'(dy) - 5'd1;
                if (!(dx == 1 && dy == 1) && xs[4:3] == 2'b00 && ys[4:3] == 2'b00)
                    rd_adj = rd_adj + {3'b000, bomb_map[{ys[2:0], xs[2:0]}]};
            end
    end
endmodule

// File: tb/tb_bomb_placer.sv
// tb_bomb_placer: directed self-checking bench for bomb_placer
module tb_bomb_placer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bombas = '0;
    logic [2:0]  safe_x = '0;
    logic [2:0]  safe_y = '0;
    logic        busy, done;
    logic [63:0] bomb_map;
    logic [3:0]  bomb_count;
    logic [2:0]  rd_x = '0;
    logic [2:0]  rd_y = '0;
    logic        rd_bomb;
    logic [3:0]  rd_adj;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] m1, m2, m3, snap;

    bomb_placer dut (
        .clk(clk), .rst(rst), .start(start), .bombas(bombas),
        .safe_x(safe_x), .safe_y(safe_y), .busy(busy), .done(done),
        .bomb_map(bomb_map), .bomb_count(bomb_count),
        .rd_x(rd_x), .rd_y(rd_y), .rd_bomb(rd_bomb), .rd_adj(rd_adj)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    function automatic int adj_model(input logic [63:0] m, input int x, input int y);
        int s = 0;
        for (int j = y - 1; j <= y + 1; j++)
            for (int i = x - 1; i <= x + 1; i++)
                if ((i != x || j != y) && i >= 0 && i < 8 && j >= 0 && j < 8) s += int'(m[j*8+i]);
        return s;
    endfunction

    task automatic launch(input logic [3:0] n, input logic [2:0] sx, input logic [2:0] sy);
        start = 1'b1;
        bombas = n;
        safe_x = sx;
        safe_y = sy;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_from_reset(input int d, output logic [63:0] m);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (d) @(negedge clk);
        launch(4'd1, 3'd0, 3'd0);
        wait_done("det_done", 200);
        m = bomb_map;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("por_busy", {63'd0, busy}, 64'd0);
        chk("por_done", {63'd0, done}, 64'd0);
        chk("por_map", bomb_map, 64'd0);
        chk("por_count", {60'd0, bomb_count}, 64'd0);

        launch(4'd15, 3'd1, 3'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_map", bomb_map, 64'd0);
        chk("midrst_count", {60'd0, bomb_count}, 64'd0);
        for (int c = 0; c < 64; c++) begin
            rd_x = 3'(c % 8);
            rd_y = 3'(c / 8);
            #1;
            chk("midrst_adj", {60'd0, rd_adj}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        launch(4'd0, 3'd0, 3'd0);
        chk("zero_busy_t1", {63'd0, busy}, 64'd1);
        chk("zero_done_t1", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("zero_done_t2", {63'd0, done}, 64'd1);
        chk("zero_busy_t2", {63'd0, busy}, 64'd0);
        chk("zero_map", bomb_map, 64'd0);

        launch(4'd15, 3'd3, 3'd4);
        wait_done("full_done", 2000);
        chk("full_pop", 64'($countones(bomb_map)), 64'd15);
        chk("full_count", {60'd0, bomb_count}, 64'd15);
        chk("full_safe_bit", {63'd0, bomb_map[35]}, 64'd0);
        chk("full_both", {63'd0, busy & done}, 64'd0);
        snap = bomb_map;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                rd_x = 3'(x);
                rd_y = 3'(y);
                #1;
                chk($sformatf("rd_bomb_%0d_%0d", x, y), {63'd0, rd_bomb}, {63'd0, snap[y*8+x]});
                chk($sformatf("rd_adj_%0d_%0d", x, y), {60'd0, rd_adj}, 64'(adj_model(snap, x, y)));
            end

        launch(4'd10, 3'd2, 3'd2);
        @(negedge clk);
        launch(4'd3, 3'd5, 3'd5);
        chk("ign_busy", {63'd0, busy}, 64'd1);
        wait_done("ign_done", 2000);
        chk("ign_count", {60'd0, bomb_count}, 64'd10);
        chk("ign_pop", 64'($countones(bomb_map)), 64'd10);
        chk("ign_safe_bit", {63'd0, bomb_map[18]}, 64'd0);

        launch(4'd5, 3'd0, 3'd7);
        chk("again_done_drop", {63'd0, done}, 64'd0);
        chk("again_busy", {63'd0, busy}, 64'd1);
        wait_done("again_done", 2000);
        chk("again_pop", 64'($countones(bomb_map)), 64'd5);
        chk("again_count", {60'd0, bomb_count}, 64'd5);
        chk("again_safe_bit", {63'd0, bomb_map[56]}, 64'd0);

        run_from_reset(20, m1);
        run_from_reset(20, m2);
        run_from_reset(21, m3);
        chk("det_same", m1, m2);
        chk("det_pop", 64'($countones(m1)), 64'd1);
        chk("det_diff", {63'd0, m1 !== m3}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
